// File: rtl/riscv32_lsu.sv
// riscv32_lsu: byte/half/word load-store unit in front of a word-wide,
// 1-cycle synchronous-read data memory. Sub-word stores use read-modify-write.
// Optional macro RISCV_LSU_MISALIGN_CHK_EN: misaligned H/W accesses return an
// error instead of being force-aligned.
module riscv32_lsu #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned MEM_ADDR_BITS = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_wen,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            mem_en,
    output logic            mem_wen,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_RD_DATA, S_WR, S_ERR, S_RESP
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [MEM_ADDR_BITS-1:0] r_addr;
    logic [2:0]               r_funct3;
    logic                     r_wen;
    logic [XLEN-1:0]          r_wdata;
    logic [XLEN-1:0]          r_resp_rdata;
    logic                     r_resp_err;

    logic                     w_accept;
    logic                     w_illegal;
    logic                     w_misalign;
    logic [MEM_ADDR_BITS-1:0] w_addr_capt;
    logic [7:0]               w_byte;
    logic [15:0]              w_half;
    logic [XLEN-1:0]          w_load_data;
    logic [XLEN-1:0]          w_merge_data;
    logic                     w_unused;

    assign w_accept = req_valid && (r_state == S_IDLE);
    assign w_unused = ^req_addr[XLEN-1:MEM_ADDR_BITS];

    // Decode illegal funct3 for loads and stores
    always_comb begin
        w_illegal = 1'b0;
        if (req_wen) begin
            w_illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
        end else begin
            w_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        end
    end

    // Clear address bits below the access size; misalignment detection is optional
    always_comb begin
        w_addr_capt = req_addr[MEM_ADDR_BITS-1:0];
        w_misalign  = 1'b0;
        case (req_funct3[1:0])
            2'b01: w_addr_capt[0]   = 1'b0;
            2'b10: w_addr_capt[1:0] = 2'b00;
            default: ;
        endcase
`ifdef RISCV_LSU_MISALIGN_CHK_EN
        case (req_funct3[1:0])
            2'b01:   w_misalign = req_addr[0];
            2'b10:   w_misalign = |req_addr[1:0];
            default: w_misalign = 1'b0;
        endcase
`endif
    end

    // Lane selection, load extension and sub-word store merge
    always_comb begin
        case (r_addr[1:0])
            2'b00:   w_byte = mem_rdata[7:0];
            2'b01:   w_byte = mem_rdata[15:8];
            2'b10:   w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (r_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {24'h0, w_byte};
            3'b101:  w_load_data = {16'h0, w_half};
            default: w_load_data = mem_rdata;
        endcase

        w_merge_data = mem_rdata;
        if (r_funct3[1:0] == 2'b00) begin
            case (r_addr[1:0])
                2'b00:   w_merge_data[7:0]   = r_wdata[7:0];
                2'b01:   w_merge_data[15:8]  = r_wdata[7:0];
                2'b10:   w_merge_data[23:16] = r_wdata[7:0];
                default: w_merge_data[31:24] = r_wdata[7:0];
            endcase
        end else if (r_addr[1]) begin
            w_merge_data[31:16] = r_wdata[15:0];
        end else begin
            w_merge_data[15:0] = r_wdata[15:0];
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_illegal || w_misalign)                  w_state_next = S_ERR;
                    else if (req_wen && (req_funct3 == 3'b010))  w_state_next = S_WR;
                    else                                          w_state_next = S_RD;
                end
            end
            S_RD:      w_state_next = S_RD_DATA;
            S_RD_DATA: w_state_next = r_wen ? S_WR : S_RESP;
            S_WR:      w_state_next = S_RESP;
            S_ERR:     w_state_next = S_RESP;
            S_RESP:    w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state and captured request only
    always_comb begin
        req_ready  = (r_state == S_IDLE);
        resp_valid = (r_state == S_RESP);
        mem_en     = 1'b0;
        mem_wen    = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        resp_rdata = r_resp_rdata;
        resp_err   = r_resp_err;
        if ((r_state == S_RD) || (r_state == S_WR)) begin
            mem_en   = 1'b1;
            mem_addr = XLEN'({r_addr[MEM_ADDR_BITS-1:2], 2'b00});
        end
        if (r_state == S_WR) begin
            mem_wen   = 1'b1;
            mem_wdata = r_wdata;
        end
    end

    // Request capture, merged-word latch and response data registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr       <= '0;
            r_funct3     <= '0;
            r_wen        <= 1'b0;
            r_wdata      <= '0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr   <= w_addr_capt;
                r_funct3 <= req_funct3;
                r_wen    <= req_wen;
                r_wdata  <= req_wdata;
            end
            case (r_state)
                S_RD_DATA: begin
                    if (r_wen) begin
                        r_wdata <= w_merge_data;
                    end else begin
                        r_resp_rdata <= w_load_data;
                        r_resp_err   <= 1'b0;
                    end
                end
                S_WR: begin
                    r_resp_rdata <= '0;
                    r_resp_err   <= 1'b0;
                end
                S_ERR: begin
                    r_resp_rdata <= '0;
                    r_resp_err   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv32_lsu.sv
// Testbench for riscv32_lsu: word memory model, reference model feeding an
// expectation queue, and one task per scenario.
`timescale 1ns/1ps
module tb_riscv32_lsu;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_en;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    riscv32_lsu #(.XLEN(32), .MEM_ADDR_BITS(16)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    // Data memory with a backdoor preload port
    logic [31:0] mem   [0:16383];
    logic [31:0] model [0:16383];
    logic        bd_we;
    logic [13:0] bd_idx;
    logic [31:0] bd_data;

    always @(posedge clock) begin
        if (bd_we) mem[bd_idx] <= bd_data;
        else if (mem_en) begin
            if (mem_wen) mem[mem_addr[15:2]] <= mem_wdata;
            else         mem_rdata <= mem[mem_addr[15:2]];
        end
    end

    typedef struct {
        int          lat;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    int errors = 0;
    int checks = 0;

    // Observations of the last transaction
    logic        ob_got, ob_err, ob_saw_en, ob_ready_low;
    int          ob_lat, ob_wen_lat;
    logic [31:0] ob_rdata, ob_wen_addr, ob_wen_data;

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        bd_we = 1'b1; bd_idx = a[15:2]; bd_data = d;
        model[a[15:2]] = d;
        @(negedge clock);
        bd_we = 1'b0;
    endtask

    // Reference model: push the expected response and update the model memory
    task automatic predict(input logic wen, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        logic ill, mis;
        logic [4:0] sh;
        logic [31:0] w, v, m;
        ill = wen ? (f3 > 3'd2)
                  : !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        mis = 1'b0;
`ifdef RISCV_LSU_MISALIGN_CHK_EN
        if (f3[1:0] == 2'd1)      mis = a[0];
        else if (f3[1:0] == 2'd2) mis = (a[1:0] != 2'd0);
`endif
        case (f3[1:0])
            2'd0:    sh = {a[1:0], 3'b000};
            2'd1:    sh = {a[1], 4'b0000};
            default: sh = 5'd0;
        endcase
        w = model[a[15:2]];
        v = w >> sh;
        e.rdata = 32'h0;
        e.err   = 1'b0;
        if (ill || mis) begin
            e.err = 1'b1; e.lat = 2;
        end else if (wen) begin
            if (f3 == 3'd2) begin
                model[a[15:2]] = wd; e.lat = 2;
            end else begin
                m = ((f3 == 3'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
                model[a[15:2]] = (w & ~m) | ((wd << sh) & m);
                e.lat = 4;
            end
        end else begin
            e.lat = 3;
            case (f3)
                3'd0:    e.rdata = {{24{v[7]}}, v[7:0]};
                3'd1:    e.rdata = {{16{v[15]}}, v[15:0]};
                3'd4:    e.rdata = {24'h0, v[7:0]};
                3'd5:    e.rdata = {16'h0, v[15:0]};
                default: e.rdata = w;
            endcase
        end
        sb.push_back(e);
    endtask

    // Drive one request and observe the DUT until its response (bounded)
    task automatic run_req(input logic wen, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
        int spin;
        @(negedge clock);
        req_valid = 1'b1; req_wen = wen; req_funct3 = f3; req_addr = a; req_wdata = wd;
        spin = 0;
        while (!req_ready && spin < 20) begin
            @(negedge clock);
            spin++;
        end
        @(posedge clock);
        #1 req_valid = 1'b0;
        ob_got = 1'b0; ob_lat = 0; ob_saw_en = 1'b0; ob_ready_low = 1'b1;
        ob_wen_lat = -1; ob_wen_addr = 32'h0; ob_wen_data = 32'h0;
        ob_rdata = 32'h0; ob_err = 1'b0;
        while (!ob_got && ob_lat < 20) begin
            @(negedge clock);
            ob_lat++;
            if (mem_en) ob_saw_en = 1'b1;
            if (req_ready) ob_ready_low = 1'b0;
            if (mem_wen && ob_wen_lat < 0) begin
                ob_wen_lat = ob_lat; ob_wen_addr = mem_addr; ob_wen_data = mem_wdata;
            end
            if (resp_valid) begin
                ob_got = 1'b1; ob_rdata = resp_rdata; ob_err = resp_err;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset req_ready: got %b expected 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset resp_valid: got %b expected 0", resp_valid); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset resp_rdata: got %h expected 0", resp_rdata); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset resp_err: got %b expected 0", resp_err); end
        checks++; if ({mem_en, mem_wen} !== 2'b00) begin errors++; $display("FAIL reset mem_en/wen: got %b expected 00", {mem_en, mem_wen}); end
        checks++; if ({mem_addr, mem_wdata} !== 64'h0) begin errors++; $display("FAIL reset mem_addr/wdata: got %h/%h expected 0/0", mem_addr, mem_wdata); end
        reset = 1'b0;
    endtask

    task automatic test_loads();
        logic [2:0]  f3s [5];
        logic [31:0] as  [5];
        exp_t e;
        f3s = '{3'd0, 3'd4, 3'd5, 3'd1, 3'd2};
        as  = '{32'h101, 32'h101, 32'h102, 32'h102, 32'h100};
        preload(32'h100, 32'h8899AABB);
        for (int i = 0; i < 5; i++) begin
            predict(1'b0, f3s[i], as[i], 32'h0);
            run_req(1'b0, f3s[i], as[i], 32'h0);
            e = sb.pop_front();
            checks++; if (!ob_got || ob_lat != e.lat) begin errors++; $display("FAIL load%0d latency: got %0d (resp=%b) expected %0d", i, ob_lat, ob_got, e.lat); end
            checks++; if (ob_rdata !== e.rdata) begin errors++; $display("FAIL load%0d rdata: got %h expected %h", i, ob_rdata, e.rdata); end
            checks++; if (ob_err !== e.err) begin errors++; $display("FAIL load%0d err: got %b expected %b", i, ob_err, e.err); end
        end
        // Fixed values from the reference word, independent of the model
        checks++; if (model[32'h100 >> 2] !== 32'h8899AABB) begin errors++; $display("FAIL load model word: got %h expected 8899aabb", model[32'h100 >> 2]); end
    endtask

    task automatic test_store_byte();
        exp_t e;
        predict(1'b1, 3'd0, 32'h103, 32'h12345677);
        run_req(1'b1, 3'd0, 32'h103, 32'h12345677);
        e = sb.pop_front();
        checks++; if (ob_wen_lat != 3) begin errors++; $display("FAIL sb wen cycle: got %0d expected 3", ob_wen_lat); end
        checks++; if (ob_wen_addr !== 32'h100) begin errors++; $display("FAIL sb mem_addr: got %h expected 00000100", ob_wen_addr); end
        checks++; if (ob_wen_data !== 32'h7799AABB) begin errors++; $display("FAIL sb mem_wdata: got %h expected 7799aabb", ob_wen_data); end
        checks++; if (!ob_got || ob_lat != e.lat) begin errors++; $display("FAIL sb latency: got %0d (resp=%b) expected %0d", ob_lat, ob_got, e.lat); end
        checks++; if (ob_rdata !== 32'h0 || ob_err !== 1'b0) begin errors++; $display("FAIL sb resp: got %h/%b expected 0/0", ob_rdata, ob_err); end
        checks++; if (mem[32'h100 >> 2] !== 32'h7799AABB) begin errors++; $display("FAIL sb memory: got %h expected 7799aabb", mem[32'h100 >> 2]); end
    endtask

    task automatic test_sw_lw();
        exp_t e;
        predict(1'b1, 3'd2, 32'h200, 32'hDEADBEEF);
        run_req(1'b1, 3'd2, 32'h200, 32'hDEADBEEF);
        e = sb.pop_front();
        checks++; if (ob_wen_lat != 1) begin errors++; $display("FAIL sw wen cycle: got %0d expected 1", ob_wen_lat); end
        checks++; if (!ob_got || ob_lat != e.lat) begin errors++; $display("FAIL sw latency: got %0d (resp=%b) expected %0d", ob_lat, ob_got, e.lat); end
        checks++; if (ob_ready_low !== 1'b1) begin errors++; $display("FAIL sw req_ready low: got %b expected 1", ob_ready_low); end
        predict(1'b0, 3'd2, 32'h200, 32'h0);
        run_req(1'b0, 3'd2, 32'h200, 32'h0);
        e = sb.pop_front();
        checks++; if (ob_rdata !== 32'hDEADBEEF || ob_rdata !== e.rdata) begin errors++; $display("FAIL lw after sw: got %h expected deadbeef", ob_rdata); end
        checks++; if (!ob_got || ob_lat != e.lat) begin errors++; $display("FAIL lw latency: got %0d expected %0d", ob_lat, e.lat); end
    endtask

    task automatic test_misalign();
        logic        wens [3];
        logic [2:0]  f3s  [3];
        logic [31:0] as   [3];
        logic        exp_en;
        exp_t e;
        wens = '{1'b0, 1'b0, 1'b1};
        f3s  = '{3'd2, 3'd3, 3'd4};
        as   = '{32'h102, 32'h100, 32'h100};
        for (int i = 0; i < 3; i++) begin
            predict(wens[i], f3s[i], as[i], 32'hCAFEF00D);
            run_req(wens[i], f3s[i], as[i], 32'hCAFEF00D);
            e = sb.pop_front();
            exp_en = !e.err;
            checks++; if (!ob_got || ob_lat != e.lat) begin errors++; $display("FAIL err%0d latency: got %0d (resp=%b) expected %0d", i, ob_lat, ob_got, e.lat); end
            checks++; if (ob_err !== e.err) begin errors++; $display("FAIL err%0d resp_err: got %b expected %b", i, ob_err, e.err); end
            checks++; if (ob_rdata !== e.rdata) begin errors++; $display("FAIL err%0d rdata: got %h expected %h", i, ob_rdata, e.rdata); end
            checks++; if (ob_saw_en !== exp_en) begin errors++; $display("FAIL err%0d mem_en seen: got %b expected %b", i, ob_saw_en, exp_en); end
        end
    endtask

    task automatic test_reset_mid();
        logic saw_wen, saw_resp;
        saw_wen = 1'b0; saw_resp = 1'b0;
        @(negedge clock);
        req_valid = 1'b1; req_wen = 1'b1; req_funct3 = 3'd1; req_addr = 32'h100; req_wdata = 32'h5555;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        saw_wen |= mem_wen; saw_resp |= resp_valid;
        @(negedge clock);
        saw_wen |= mem_wen; saw_resp |= resp_valid;
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid req_ready: got %b expected 1", req_ready); end
        repeat (6) begin
            saw_wen |= mem_wen; saw_resp |= resp_valid;
            @(negedge clock);
        end
        checks++; if (saw_wen !== 1'b0) begin errors++; $display("FAIL rstmid mem_wen: got %b expected 0", saw_wen); end
        checks++; if (saw_resp !== 1'b0) begin errors++; $display("FAIL rstmid resp_valid: got %b expected 0", saw_resp); end
        checks++; if (mem[32'h100 >> 2] !== model[32'h100 >> 2]) begin errors++; $display("FAIL rstmid memory: got %h expected %h", mem[32'h100 >> 2], model[32'h100 >> 2]); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ldf [5];
        logic        wens [24];
        logic [2:0]  f3s  [24];
        logic [31:0] as   [24];
        logic [31:0] wds  [24];
        exp_t e;
        ldf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int i = 0; i < 16; i++) preload(32'h300 + 32'(4 * i), $urandom);
        for (int i = 0; i < 24; i++) begin
            wens[i] = 1'($urandom_range(0, 1));
            f3s[i]  = wens[i] ? 3'($urandom_range(0, 2)) : ldf[$urandom_range(0, 4)];
            as[i]   = 32'h300 + 32'(4 * $urandom_range(0, 15));
            if (f3s[i][1:0] == 2'd0)      as[i] = as[i] + 32'($urandom_range(0, 3));
            else if (f3s[i][1:0] == 2'd1) as[i] = as[i] + 32'(2 * $urandom_range(0, 1));
            wds[i]  = $urandom;
            predict(wens[i], f3s[i], as[i], wds[i]);
        end
        for (int i = 0; i < 24; i++) begin
            run_req(wens[i], f3s[i], as[i], wds[i]);
            e = sb.pop_front();
            checks++; if (!ob_got || ob_lat != e.lat || ob_rdata !== e.rdata || ob_err !== e.err)
                begin errors++; $display("FAIL b2b%0d: got lat=%0d rdata=%h err=%b expected lat=%0d rdata=%h err=%b", i, ob_lat, ob_rdata, ob_err, e.lat, e.rdata, e.err); end
        end
        for (int i = 0; i < 16; i++) begin
            checks++; if (mem[(32'h300 >> 2) + i] !== model[(32'h300 >> 2) + i])
                begin errors++; $display("FAIL b2b mem%0d: got %h expected %h", i, mem[(32'h300 >> 2) + i], model[(32'h300 >> 2) + i]); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = 1'b0; req_wen = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
        bd_we = 1'b0; bd_idx = 14'h0; bd_data = 32'h0;
        test_reset();
        test_loads();
        test_store_byte();
        test_sw_lw();
        test_misalign();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
